rx_seg_release_sched: RTL and testbench

- In-order release scheduler for the redundant-frame receive path.
- Per-segment majority voters report when a segment's voted payload is complete. This block records those reports in a bitmap and grants the shared output bus to one segment at a time, in ascending segment order.
- If the expected segment never arrives while later segments are waiting, the block skips it after a timeout.
- Sits between the per-segment voter bank and the downstream frame sink.

---
 rtl/rx_seg_release_sched.sv | 132 +++++++++++++
 tb/tb_rx_seg_release_sched.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_seg_release_sched.sv
// In-order release scheduler: records voter "segment ready" reports in a bitmap and
// grants the output bus to one segment at a time, skipping a missing segment after a timeout.
module rx_seg_release_sched #(
    parameter int SEGMENT_NUM_MAX = 100,
    parameter int TIMEOUT_CYCLES  = 125000,
    parameter int TO_W            = 17
) (
    input  logic        clk125MHz,
    input  logic        reset,
    input  logic        rdy_valid,
    input  logic [15:0] rdy_seg,
    output logic        grant_valid,
    output logic [15:0] grant_seg,
    input  logic        play_done,
    output logic        skip_pulse,
    output logic        rdy_err,
    output logic [15:0] skip_count,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_GRANT = 2'd1,
        ST_SKIP  = 2'd2
    } state_t;

    localparam logic [SEGMENT_NUM_MAX-1:0] ONE_HOT0 = SEGMENT_NUM_MAX'(1);
    localparam logic [TO_W-1:0]            CNT_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0]                SEG_LAST = 16'(SEGMENT_NUM_MAX - 1);

    state_t                     state, state_next;
    logic [SEGMENT_NUM_MAX-1:0] bitmap, bitmap_next;
    logic [SEGMENT_NUM_MAX-1:0] rdy_mask, grant_mask, set_mask, clr_mask;
    logic [TO_W-1:0]            cnt, cnt_next;
    logic [15:0]                grant_next, seg_advance;
    logic                       rdy_in_range, rdy_is_grant, rdy_err_next;
    logic                       grant_hit, timeout_hit;

    // Shifting a one-hot seed keeps out-of-range indices harmless: they shift to zero.
    assign rdy_mask     = ONE_HOT0 << rdy_seg;
    assign grant_mask   = ONE_HOT0 << grant_seg;
    assign rdy_in_range = rdy_seg < 16'(SEGMENT_NUM_MAX);
    assign rdy_is_grant = rdy_seg == grant_seg;
    assign grant_hit    = |(bitmap & grant_mask);
    assign timeout_hit  = cnt == CNT_LAST;
    assign seg_advance  = (grant_seg == SEG_LAST) ? 16'd0 : grant_seg + 16'd1;

    always_comb begin
        state_next   = state;
        grant_next   = grant_seg;
        cnt_next     = cnt;
        set_mask     = '0;
        clr_mask     = '0;
        rdy_err_next = 1'b0;

        // A report for the segment currently on the bus is treated as a duplicate.
        if (rdy_valid) begin
            if (!rdy_in_range || (|(bitmap & rdy_mask)) ||
                (state == ST_GRANT && rdy_is_grant)) begin
                rdy_err_next = 1'b1;
            end else begin
                set_mask = rdy_mask;
            end
        end

        case (state)
            ST_WAIT: begin
                if (grant_hit) begin
                    state_next = ST_GRANT;
                    cnt_next   = '0;
                end else if (timeout_hit) begin
                    cnt_next = '0;
                    // A late report for the expected segment beats the timeout.
                    if (rdy_valid && rdy_is_grant) begin
                        state_next = ST_GRANT;
                    end else begin
                        state_next = ST_SKIP;
                    end
                end else if (|bitmap) begin
                    cnt_next = cnt + TO_W'(1);
                end else begin
                    cnt_next = '0;
                end
            end
            ST_GRANT: begin
                if (play_done) begin
                    clr_mask   = grant_mask;
                    grant_next = seg_advance;
                    cnt_next   = '0;
                    state_next = ST_WAIT;
                end
            end
            ST_SKIP: begin
                grant_next = seg_advance;
                cnt_next   = '0;
                state_next = ST_WAIT;
            end
            default: begin
                state_next = ST_WAIT;
                cnt_next   = '0;
            end
        endcase

        bitmap_next = (bitmap & ~clr_mask) | set_mask;
    end

    always_ff @(posedge clk125MHz or posedge reset) begin
        if (reset) begin
            state      <= ST_WAIT;
            bitmap     <= '0;
            grant_seg  <= 16'd0;
            cnt        <= '0;
            rdy_err    <= 1'b0;
            busy       <= 1'b0;
            skip_count <= 16'd0;
        end else begin
            state     <= state_next;
            bitmap    <= bitmap_next;
            grant_seg <= grant_next;
            cnt       <= cnt_next;
            rdy_err   <= rdy_err_next;
            busy      <= (|bitmap_next) | (state_next == ST_GRANT);
            if (state_next == ST_SKIP && skip_count != 16'hFFFF) begin
                skip_count <= skip_count + 16'd1;
            end
        end
    end

    assign grant_valid = state == ST_GRANT;
    assign skip_pulse  = state == ST_SKIP;

endmodule

// File: tb/tb_rx_seg_release_sched.sv
// Scoreboard bench for rx_seg_release_sched: a behavioural model predicts grant, skip and
// error events into queues; a negedge monitor pops and compares them against the DUT.
module tb_rx_seg_release_sched;

    localparam int SEG_N   = 100;
    localparam int TIMEOUT = 16;

    typedef struct {
        int seg;
        int cyc;
        int cnt;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rdy_valid = 1'b0;
    logic [15:0] rdy_seg = 16'd0;
    logic        play_done = 1'b0;
    logic        grant_valid;
    logic [15:0] grant_seg;
    logic        skip_pulse;
    logic        rdy_err;
    logic [15:0] skip_count;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    bit  m_ready [SEG_N];
    int  m_expected, m_waited, m_skips, m_set, m_s;
    bit  m_granted, m_skipping, m_busy;
    ev_t grant_q[$], skip_q[$], err_q[$];
    ev_t mon_ev;
    bit  prev_gv;

    rx_seg_release_sched #(
        .SEGMENT_NUM_MAX(SEG_N),
        .TIMEOUT_CYCLES (TIMEOUT),
        .TO_W           (5)
    ) dut (
        .clk125MHz  (clk),
        .reset      (reset),
        .rdy_valid  (rdy_valid),
        .rdy_seg    (rdy_seg),
        .grant_valid(grant_valid),
        .grant_seg  (grant_seg),
        .play_done  (play_done),
        .skip_pulse (skip_pulse),
        .rdy_err    (rdy_err),
        .skip_count (skip_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic ev_t mkEv(input int seg, input int c, input int n);
        ev_t e;
        e.seg = seg;
        e.cyc = c;
        e.cnt = n;
        return e;
    endfunction

    function automatic bit anyReady();
        for (int i = 0; i < SEG_N; i++) begin
            if (m_ready[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [15:0] s, input logic p);
        @(negedge clk);
        #1;
        rdy_valid = v;
        rdy_seg   = s;
        play_done = p;
    endtask

    task automatic resetDut();
        rdy_valid = 1'b0;
        rdy_seg   = 16'd0;
        play_done = 1'b0;
        reset     = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // Pulse play_done whenever the model holds a grant, until nothing is pending.
    task automatic serveUntilIdle(input int maxCycles);
        int n = 0;
        while ((m_granted || anyReady()) && n < maxCycles) begin
            if (m_granted) applyStimulus(1'b0, 16'd0, 1'b1);
            else applyStimulus(1'b0, 16'd0, 1'b0);
            n++;
        end
        applyStimulus(1'b0, 16'd0, 1'b0);
        checkOutput("serve_within_bound", n < maxCycles, 1);
    endtask

    task automatic waitGrant(input int maxCycles);
        int n = 0;
        while (!m_granted && n < maxCycles) begin
            applyStimulus(1'b0, 16'd0, 1'b0);
            n++;
        end
        checkOutput("grant_within_bound", m_granted, 1);
    endtask

    // Reference model, stepped from the spec's rules at every clock edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SEG_N; i++) m_ready[i] = 1'b0;
            m_expected = 0;
            m_waited   = 0;
            m_skips    = 0;
            m_granted  = 1'b0;
            m_skipping = 1'b0;
            m_busy     = 1'b0;
            grant_q.delete();
            skip_q.delete();
            err_q.delete();
        end else begin
            cyc++;
            m_set = -1;
            if (rdy_valid) begin
                m_s = int'(rdy_seg);
                if (m_s >= SEG_N) begin
                    err_q.push_back(mkEv(m_s, cyc, 0));
                end else if (m_ready[m_s] || (m_granted && m_s == m_expected)) begin
                    err_q.push_back(mkEv(m_s, cyc, 0));
                end else begin
                    m_set = m_s;
                end
            end
            if (m_granted) begin
                if (play_done) begin
                    m_ready[m_expected] = 1'b0;
                    m_expected = (m_expected + 1) % SEG_N;
                    m_granted  = 1'b0;
                end
            end else if (m_skipping) begin
                m_expected = (m_expected + 1) % SEG_N;
                m_skipping = 1'b0;
            end else begin
                if (m_ready[m_expected]) begin
                    m_granted = 1'b1;
                    m_waited  = 0;
                end else if (m_waited == TIMEOUT - 1) begin
                    m_waited = 0;
                    if (m_set == m_expected) begin
                        m_granted = 1'b1;
                    end else begin
                        m_skipping = 1'b1;
                        if (m_skips < 65535) m_skips++;
                        skip_q.push_back(mkEv(m_expected, cyc, m_skips));
                    end
                end else if (anyReady()) begin
                    m_waited++;
                end else begin
                    m_waited = 0;
                end
                if (m_granted) grant_q.push_back(mkEv(m_expected, cyc, 0));
            end
            if (m_set >= 0) m_ready[m_set] = 1'b1;
            m_busy = anyReady() || m_granted;
        end
    end

    // Monitor: every DUT event must match the oldest predicted one.
    always @(negedge clk) begin
        if (reset) begin
            prev_gv = 1'b0;
        end else begin
            if (grant_valid && !prev_gv) begin
                checkOutput("grant_predicted", grant_q.size() != 0, 1);
                if (grant_q.size() != 0) begin
                    mon_ev = grant_q.pop_front();
                    checkOutput("grant_seg", grant_seg, mon_ev.seg);
                    checkOutput("grant_cycle", cyc, mon_ev.cyc);
                end
            end
            if (skip_pulse) begin
                checkOutput("skip_predicted", skip_q.size() != 0, 1);
                if (skip_q.size() != 0) begin
                    mon_ev = skip_q.pop_front();
                    checkOutput("skip_seg", grant_seg, mon_ev.seg);
                    checkOutput("skip_count", skip_count, mon_ev.cnt);
                    checkOutput("skip_cycle", cyc, mon_ev.cyc);
                end
            end
            if (rdy_err) begin
                checkOutput("err_predicted", err_q.size() != 0, 1);
                if (err_q.size() != 0) begin
                    mon_ev = err_q.pop_front();
                    checkOutput("err_cycle", cyc, mon_ev.cyc);
                end
            end
            checkOutput("busy", busy, m_busy);
            prev_gv = grant_valid;
        end
    end

    initial begin
        int r;
        logic [15:0] seg;

        // Reset values
        resetDut();
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_grant_valid", grant_valid, 0);
        checkOutput("rst_grant_seg", grant_seg, 0);
        checkOutput("rst_skip_pulse", skip_pulse, 0);
        checkOutput("rst_rdy_err", rdy_err, 0);
        checkOutput("rst_skip_count", skip_count, 0);
        checkOutput("rst_busy", busy, 0);
        reset = 1'b0;

        // Segment 0: grant two cycles after the report, released one cycle after play_done
        applyStimulus(1'b1, 16'd0, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b0);
        checkOutput("lat_grant_valid", grant_valid, 1);
        checkOutput("lat_grant_seg", grant_seg, 0);
        applyStimulus(1'b0, 16'd0, 1'b1);
        applyStimulus(1'b0, 16'd0, 1'b0);
        checkOutput("release_grant_valid", grant_valid, 0);
        checkOutput("release_grant_seg", grant_seg, 1);

        // Out-of-order reports 2,1,0 are released in ascending order
        resetDut();
        applyStimulus(1'b1, 16'd2, 1'b0);
        applyStimulus(1'b1, 16'd1, 1'b0);
        applyStimulus(1'b1, 16'd0, 1'b0);
        serveUntilIdle(200);
        checkOutput("order_no_skip", skip_count, 0);

        // Missing segment 0 is skipped 16 cycles after segment 1 arrives
        resetDut();
        applyStimulus(1'b1, 16'd1, 1'b0);
        repeat (17) applyStimulus(1'b0, 16'd0, 1'b0);
        checkOutput("timeout_skip_pulse", skip_pulse, 1);
        checkOutput("timeout_skip_count", skip_count, 1);
        repeat (2) applyStimulus(1'b0, 16'd0, 1'b0);
        checkOutput("after_skip_grant_valid", grant_valid, 1);
        checkOutput("after_skip_grant_seg", grant_seg, 1);
        serveUntilIdle(200);

        // Every segment reported, served through 99 and wrapping back to 0
        resetDut();
        for (int k = 0; k < SEG_N; k++) applyStimulus(1'b1, 16'(k), 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b0);
        serveUntilIdle(1000);
        checkOutput("wrap_grant_seg", grant_seg, 0);
        applyStimulus(1'b1, 16'd100, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b0);
        checkOutput("range_err", rdy_err, 1);
        checkOutput("range_busy", busy, 0);

        // Duplicate report of segment 5
        applyStimulus(1'b1, 16'd5, 1'b0);
        applyStimulus(1'b1, 16'd5, 1'b0);
        applyStimulus(1'b0, 16'd0, 1'b0);
        checkOutput("dup_err", rdy_err, 1);
        serveUntilIdle(400);

        // Asynchronous reset during a grant clears outputs without a clock edge
        applyStimulus(1'b1, 16'(m_expected), 1'b0);
        waitGrant(20);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_grant_valid", grant_valid, 0);
        checkOutput("async_busy", busy, 0);
        checkOutput("async_grant_seg", grant_seg, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Empty bitmap never times out
        repeat (2000) applyStimulus(1'b0, 16'd0, 1'b0);
        checkOutput("idle_skip_count", skip_count, 0);
        checkOutput("idle_busy", busy, 0);

        // Randomised traffic biased around the expected segment
        for (int k = 0; k < 3000; k++) begin
            r = $urandom_range(0, 9);
            if (r < 7) seg = 16'((m_expected + $urandom_range(0, 4)) % SEG_N);
            else if (r < 9) seg = 16'($urandom_range(0, SEG_N - 1));
            else seg = 16'($urandom_range(SEG_N, 65535));
            applyStimulus(($urandom_range(0, 3) == 0), seg, ($urandom_range(0, 2) == 0));
        end
        serveUntilIdle(4000);
        repeat (5) applyStimulus(1'b0, 16'd0, 1'b0);

        checkOutput("grant_q_drained", grant_q.size(), 0);
        checkOutput("skip_q_drained", skip_q.size(), 0);
        checkOutput("err_q_drained", err_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
